gf2m_digit_serial_mult: RTL and testbench



---
 rtl/gf_pkg.sv | 31 +++
 rtl/gf_digit_step.sv | 27 ++
 rtl/gf2m_digit_serial_mult.sv | 124 ++++++++++++
 tb/tb_gf2m_digit_serial_mult.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions: FSM state encoding, reduction polynomials and
// the xtime helper used by the digit-step datapath.
package gf_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} gf_state_e;

    // Widest field the xtime helper supports.
    localparam int GF_MAX_W = 64;

    localparam logic [7:0] AES_POLY  = 8'h1B;
    localparam logic [3:0] GF16_POLY = 4'h3;

    // Multiply v by x modulo (x^w + poly). v and poly carry only w live bits.
    function automatic logic [GF_MAX_W-1:0] gf_xtime(
        input logic [GF_MAX_W-1:0] v,
        input logic [GF_MAX_W-1:0] poly,
        input int                  w
    );
        logic [GF_MAX_W-1:0] r;
        logic                msb;
        r   = '0;
        msb = 1'b0;
        for (int i = 0; i < GF_MAX_W; i++) begin
            if (i == w - 1) msb = v[i];
            if (i > 0 && i < w) r[i] = v[i-1];
        end
        if (msb) r = r ^ poly;
        return r;
    endfunction

endpackage

// File: rtl/gf_digit_step.sv
// One digit of MSB-first shift-and-add GF(2^WIDTH) multiplication:
// DIGIT interleaved xtime/conditional-XOR iterations, purely combinational.
module gf_digit_step
    import gf_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DIGIT = 2,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [DIGIT-1:0] digit,
    output logic [WIDTH-1:0] acc_next
);

    logic [GF_MAX_W-1:0] t;

    always_comb begin
        t = GF_MAX_W'(acc);
        for (int j = DIGIT - 1; j >= 0; j--) begin
            t = gf_xtime(t, GF_MAX_W'(POLY), WIDTH);
            if (digit[j]) t = t ^ GF_MAX_W'(a);
        end
        acc_next = t[WIDTH-1:0];
    end

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^WIDTH) multiplier with valid/ready on both sides.
// Consumes DIGIT bits of b per cycle, MSB first; product held until taken.
module gf2m_digit_serial_mult
    import gf_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DIGIT = 2,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic             busy
);

    localparam int NDIG  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || WIDTH > GF_MAX_W ||
            (DIGIT > 0 && (WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("gf2m_digit_serial_mult: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    gf_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_next;

    gf_digit_step #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT),
        .POLY  (POLY)
    ) u_step (
        .acc      (acc_q),
        .a        (a_q),
        .digit    (b_q[WIDTH-1 -: DIGIT]),
        .acc_next (acc_next)
    );

    // Ready is asserted during reset so the block looks idle immediately;
    // the reset branch below still refuses the transfer.
    assign in_ready  = rst | (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_next;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    p_d         = acc_next;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Bench for gf2m_digit_serial_mult: AES-field vector table, random pairs
// against a polynomial-division reference, GF(16) digit sweep, corner cases.
module tb_gf2m_digit_serial_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] a, b, p;

    logic       in_valid16, out_ready16;
    logic [3:0] a16, b16;
    logic       in_ready16 [3];
    logic       out_valid16[3];
    logic       busy16     [3];
    logic [3:0] p16        [3];

    int n_chk  = 0;
    int n_fail = 0;

    gf2m_digit_serial_mult dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    gf2m_digit_serial_mult #(.WIDTH(4), .DIGIT(1), .POLY(4'h3)) dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16[0]),
        .a(a16), .b(b16), .out_valid(out_valid16[0]), .out_ready(out_ready16),
        .p(p16[0]), .busy(busy16[0])
    );

    gf2m_digit_serial_mult #(.WIDTH(4), .DIGIT(2), .POLY(4'h3)) dut_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16[1]),
        .a(a16), .b(b16), .out_valid(out_valid16[1]), .out_ready(out_ready16),
        .p(p16[1]), .busy(busy16[1])
    );

    gf2m_digit_serial_mult #(.WIDTH(4), .DIGIT(4), .POLY(4'h3)) dut_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16[2]),
        .a(a16), .b(b16), .out_valid(out_valid16[2]), .out_ready(out_ready16),
        .p(p16[2]), .busy(busy16[2])
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
    } vec8_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full carry-less product, then long division by x^w + poly.
    function automatic logic [31:0] ref_mul(input int w, input logic [31:0] poly,
                                            input logic [31:0] x, input logic [31:0] y);
        logic [63:0] prod;
        logic [63:0] modp;
        prod = '0;
        modp = (64'(1) << w) | 64'(poly);
        for (int i = 0; i < w; i++)
            if (y[i]) prod = prod ^ (64'(x) << i);
        for (int i = 2 * w - 2; i >= w; i--)
            if (prod[i]) prod = prod ^ (modp << (i - w));
        return prod[31:0];
    endfunction

    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready before issue", in_ready, 1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out8(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("out_valid timeout", 0, 1);
    endtask

    task automatic op8(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic [7:0] exp);
        int lat;
        issue8(ta, tb_);
        wait_out8(lat);
        check({name, " latency"}, lat, 4);
        check({name, " p"}, p, exp);
        @(posedge clk); #1;
        check({name, " out_valid after transfer"}, out_valid, 0);
        check({name, " in_ready after transfer"}, in_ready, 1);
    endtask

    task automatic op16(input logic [3:0] ta, input logic [3:0] tb_);
        int   lat [3];
        bit   seen[3];
        int   dig [3];
        logic [3:0] exp;
        dig = '{1, 2, 4};
        exp = ref_mul(4, 32'h3, 32'(ta), 32'(tb_))[3:0];
        for (int k = 0; k < 3; k++) begin
            lat[k]  = 0;
            seen[k] = 1'b0;
        end
        @(negedge clk);
        in_valid16 = 1'b1;
        a16        = ta;
        b16        = tb_;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && out_valid16[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = c;
                    check($sformatf("gf16 d%0d %h*%h p", dig[k], ta, tb_), p16[k], exp);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("gf16 d%0d latency", dig[k]), lat[k], 4 / dig[k]);
            check($sformatf("gf16 d%0d idle", dig[k]), in_ready16[k], 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec8_t vt[5];
        int    lat;
        logic [7:0] ra, rb;
        logic [3:0] qa, qb;

        vt[0] = '{a: 8'h57, b: 8'h83, p: 8'hC1};
        vt[1] = '{a: 8'h02, b: 8'h87, p: 8'h15};
        vt[2] = '{a: 8'h00, b: 8'hFF, p: 8'h00};
        vt[3] = '{a: 8'h01, b: 8'hA5, p: 8'hA5};
        vt[4] = '{a: 8'h57, b: 8'h13, p: 8'hFE};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset p", p, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 5; i++)
            op8($sformatf("vec%0d %h*%h", i, vt[i].a, vt[i].b), vt[i].a, vt[i].b, vt[i].p);

        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8($sformatf("rand %h*%h", ra, rb), ra, rb, ref_mul(8, 32'h1B, 32'(ra), 32'(rb))[7:0]);
        end

        op16(4'h7, 4'hB);
        check("gf16 7*B table value", p16[1], 4'h4);
        for (int i = 0; i < 16; i++) begin
            qa = 4'($urandom);
            qb = 4'($urandom);
            op16(qa, qb);
        end

        // Backpressure: product held, new operands refused.
        out_ready = 1'b0;
        issue8(8'h57, 8'h83);
        wait_out8(lat);
        check("bp latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'h11; b = 8'h11;
            @(posedge clk); #1;
            check("bp p stable", p, 8'hC1);
            check("bp in_ready low", in_ready, 0);
            check("bp out_valid held", out_valid, 1);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp out_valid after release", out_valid, 0);
        check("bp in_ready after release", in_ready, 1);
        check("bp busy after release", busy, 0);

        // Reset two cycles into CALC discards the partial product.
        issue8(8'h57, 8'h83);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        check("midrst in_ready during rst", in_ready, 1);
        @(posedge clk); #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst p", p, 0);
        check("midrst busy", busy, 0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst no stale result", out_valid, 0);
        op8("post-reset 57*13", 8'h57, 8'h13, 8'hFE);

        // Reset beats a same-edge output transfer; in_valid held through reset.
        out_ready = 1'b0;
        issue8(8'h57, 8'h83);
        wait_out8(lat);
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; a = 8'h57; b = 8'h13;
        @(posedge clk); #1;
        check("same-edge out_valid", out_valid, 0);
        check("same-edge p cleared", p, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst held busy", busy, 0);
            check("rst held in_ready", in_ready, 1);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("accept after rst falls", busy, 1);
        in_valid = 1'b0;
        wait_out8(lat);
        check("after rst latency", lat, 4);
        check("after rst p", p, 8'hFE);
        @(posedge clk); #1;
        check("after rst transfer", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
